// File: rtl/axis_fork_dispatch.sv
// axis_fork_dispatch: AXI4-Stream packet fork (round-robin / broadcast / directed) with session control.
// Define AXIS_FORK_STATUS_EN to add the per-port completed-packet counters on m_pkt_count.

module axis_fork_slice #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_last,
  input  logic                  m_tready,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  rdy
);
  assign rdy = !m_tvalid || m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= din;
      m_tlast  <= din_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end
endmodule

module axis_fork_dispatch #(
  parameter int M_COUNT       = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int PKT_CNT_WIDTH = 16,
  parameter int SEL_WIDTH     = $clog2(M_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fork_enable,
  input  logic [1:0]                    fork_mode,
  input  logic [SEL_WIDTH-1:0]          fork_sel,
  input  logic [PKT_CNT_WIDTH-1:0]      fork_pkt_num,
  output logic                          fork_busy,
  output logic                          fork_done,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT-1:0]            m_axis_tvalid
`ifdef AXIS_FORK_STATUS_EN
  ,
  output logic [M_COUNT*PKT_CNT_WIDTH-1:0] m_pkt_count
`endif
);
  localparam int PW = $clog2(M_COUNT);
  localparam logic [1:0] MODE_RR  = 2'd0;
  localparam logic [1:0] MODE_BC  = 2'd1;
  localparam logic [1:0] MODE_DIR = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               mode_q;
  logic [PW-1:0]            ptr;
  logic [PKT_CNT_WIDTH-1:0] pkt_num_q, pkt_cnt, pkt_cnt_inc;
  logic                     zero_done;
  logic [M_COUNT-1:0]       out_rdy, load;
  logic                     start, accept, last_acc, sess_end, bcast;

  assign bcast       = (mode_q == MODE_BC);
  assign start       = (state == IDLE) && fork_enable;
  assign accept      = s_axis_tvalid && s_axis_tready;
  assign last_acc    = accept && s_axis_tlast;
  assign pkt_cnt_inc = pkt_cnt + 1'b1;
  assign sess_end    = last_acc && (pkt_cnt_inc == pkt_num_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fork_enable && fork_pkt_num != '0) state_nxt = RUN;
      RUN:     if (sess_end) state_nxt = DRAIN;
      DRAIN:   if (~|m_axis_tvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Broadcast waits for every slice so no port ever holds a partial copy.
  always_comb begin
    s_axis_tready = 1'b0;
    fork_busy     = 1'b0;
    fork_done     = zero_done;
    case (state)
      RUN: begin
        fork_busy     = 1'b1;
        s_axis_tready = bcast ? &out_rdy : out_rdy[ptr];
      end
      DRAIN: begin
        fork_busy = 1'b1;
        fork_done = ~|m_axis_tvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_RR;
      ptr       <= '0;
      pkt_num_q <= '0;
      pkt_cnt   <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= start && (fork_pkt_num == '0);
      if (start) begin
        mode_q    <= (fork_mode == 2'd3) ? MODE_RR : fork_mode;
        pkt_num_q <= fork_pkt_num;
        pkt_cnt   <= '0;
        if (fork_mode != MODE_DIR)          ptr <= '0;
        else if (32'(fork_sel) >= M_COUNT)  ptr <= PW'(M_COUNT - 1);
        else                                ptr <= PW'(fork_sel);
      end else if (last_acc) begin
        // Pointer only moves on a packet boundary.
        pkt_cnt <= pkt_cnt_inc;
        if (mode_q == MODE_RR)
          ptr <= (32'(ptr) == M_COUNT - 1) ? '0 : ptr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < M_COUNT; g++) begin : g_port
    assign load[g] = accept && (bcast || ptr == PW'(g));

    axis_fork_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
      .clk      (clk),
      .rst_n    (rst),
      .load     (load[g]),
      .din      (s_axis_tdata),
      .din_last (s_axis_tlast),
      .m_tready (m_axis_tready[g]),
      .m_tvalid (m_axis_tvalid[g]),
      .m_tdata  (m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .m_tlast  (m_axis_tlast[g]),
      .rdy      (out_rdy[g])
    );
  end

`ifdef AXIS_FORK_STATUS_EN
  logic [M_COUNT-1:0][PKT_CNT_WIDTH-1:0] port_pkts;

  for (genvar g = 0; g < M_COUNT; g++) begin : g_stat
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        port_pkts[g] <= '0;
      else if (start)
        port_pkts[g] <= '0;
      else if (m_axis_tvalid[g] && m_axis_tready[g] && m_axis_tlast[g] && port_pkts[g] != '1)
        port_pkts[g] <= port_pkts[g] + 1'b1;
    end
  end

  assign m_pkt_count = port_pkts;
`endif
endmodule

// File: tb/tb_axis_fork_dispatch.sv
// Bench for axis_fork_dispatch: session table + per-port scoreboard, plus a mid-packet reset sequence.

module tb_axis_fork_dispatch;
  localparam int M   = 4;
  localparam int DW  = 64;
  localparam int PCW = 16;
  localparam int SW  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fork_enable = 1'b0;
  logic [1:0]        fork_mode = '0;
  logic [SW-1:0]     fork_sel = '0;
  logic [PCW-1:0]    fork_pkt_num = '0;
  logic              fork_busy, fork_done, s_axis_tready;
  logic [DW-1:0]     s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic [M-1:0]      m_axis_tready = '1;
  logic [M*DW-1:0]   m_axis_tdata;
  logic [M-1:0]      m_axis_tlast, m_axis_tvalid;
`ifdef AXIS_FORK_STATUS_EN
  logic [M*PCW-1:0]  m_pkt_count;
`endif

  axis_fork_dispatch #(.M_COUNT(M), .DATA_WIDTH(DW), .PKT_CNT_WIDTH(PCW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .fork_enable(fork_enable), .fork_mode(fork_mode), .fork_sel(fork_sel),
    .fork_pkt_num(fork_pkt_num), .fork_busy(fork_busy), .fork_done(fork_done),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid)
`ifdef AXIS_FORK_STATUS_EN
    , .m_pkt_count(m_pkt_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      mode;
    logic [SW-1:0]   sel;
    int              num;
    int              bpp;
    int              stall;
    logic [3:0][7:0] exp_beats;
    logic [3:0][7:0] exp_pkts;
  } vec_t;

  vec_t vecs[8];
  vec_t post_rst_vec;

  int checks = 0;
  int errors = 0;

  // session context written by the driver only
  int mdl_mode, mdl_num, mdl_p0, sess_id = 0;
  int run0 = 1 << 20;
  int stall_mode = 0;
  int cyc = 0;

  // monitor-owned state and running totals
  logic [DW:0] sbq[M][$];
  int beats_tot[M];
  int done_tot = 0, busy_tot = 0, trdy_tot = 0, extra_tot = 0;
  int done_cyc = -1, last_m_cyc = -1;
  int mdl_p = 0, mdl_cnt = 0, seen_id = 0;

  function automatic logic [3:0][7:0] mk(input int b0, input int b1, input int b2, input int b3);
    logic [3:0][7:0] r;
    r[0] = 8'(b0); r[1] = 8'(b1); r[2] = 8'(b2); r[3] = 8'(b3);
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // sink ready patterns; cyc advances on every rising edge
  initial begin
    logic [M-1:0] t;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < M; i++) begin
        case (stall_mode)
          1:       t[i] = ($urandom_range(0, 3) != 0);
          2:       t[i] = !(i == 2 && cyc - run0 >= 3 && cyc - run0 <= 7);
          default: t[i] = 1'b1;
        endcase
      end
      m_axis_tready = t;
    end
  end

  // scoreboard: push on slave accept, pop on master handshake
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst) begin
      for (int i = 0; i < M; i++) sbq[i].delete();
      mdl_cnt = 1 << 30;
    end else begin
      if (sess_id != seen_id) begin
        seen_id = sess_id;
        mdl_p   = mdl_p0;
        mdl_cnt = 0;
      end
      if (fork_done) begin done_tot++; done_cyc = cyc; end
      if (fork_busy) busy_tot++;
      if (s_axis_tready) trdy_tot++;
      if (stall_mode == 2 && fork_busy && cyc - run0 >= 3 && cyc - run0 <= 7)
        chk($sformatf("bc_stall_tready_c%0d", cyc - run0), 64'(s_axis_tready), 64'd0);
      for (int i = 0; i < M; i++) begin
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          beats_tot[i]++;
          last_m_cyc = cyc;
          if (sbq[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected port=%0d actual=%0h expected=none", i, m_axis_tdata[i*DW +: DW]);
          end else begin
            e = sbq[i].pop_front();
            chk($sformatf("sb_data_p%0d", i), m_axis_tdata[i*DW +: DW], e[DW-1:0]);
            chk($sformatf("sb_last_p%0d", i), 64'(m_axis_tlast[i]), 64'(e[DW]));
          end
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (mdl_cnt >= mdl_num) extra_tot++;
        else begin
          for (int i = 0; i < M; i++)
            if (mdl_mode == 1 || i == mdl_p) sbq[i].push_back({s_axis_tlast, s_axis_tdata});
          if (s_axis_tlast) begin
            mdl_cnt++;
            if (mdl_mode == 0 || mdl_mode == 3) mdl_p = (mdl_p + 1) % M;
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l, output bit ok);
    int w = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l;
    do begin @(negedge clk); w++; end while (!s_axis_tready && w < 1000);
    ok = s_axis_tready;
    @(posedge clk); #1;
  endtask

  // begins at posedge+1 with the DUT idle
  task automatic start_session(input vec_t v, output int c_en);
    mdl_mode = v.mode;
    mdl_num  = v.num;
    mdl_p0   = (v.mode == 2) ? ((int'(v.sel) >= M) ? M - 1 : int'(v.sel)) : 0;
    sess_id++;
    fork_enable = 1'b1; fork_mode = v.mode; fork_sel = v.sel; fork_pkt_num = PCW'(v.num);
    c_en = cyc; run0 = c_en + 1; stall_mode = v.stall;
    @(posedge clk); #1;
    fork_enable = 1'b0;
    fork_mode = 2'($urandom); fork_sel = SW'($urandom); fork_pkt_num = PCW'($urandom);
  endtask

  task automatic run_session(input vec_t v, input int idx);
    int c_en, w, left;
    int b_beats[M];
    int b_done, b_busy, b_trdy, b_extra;
    bit ok;
    for (int i = 0; i < M; i++) b_beats[i] = beats_tot[i];
    b_done = done_tot; b_busy = busy_tot; b_trdy = trdy_tot; b_extra = extra_tot;
    start_session(v, c_en);
    for (int p = 0; p < v.num; p++)
      for (int b = 0; b < v.bpp; b++) begin
        send_beat({$urandom, $urandom}, b == v.bpp - 1, ok);
        if (!ok) begin
          checks++; errors++;
          $display("FAIL v%0d_beat_timeout actual=stalled expected=accepted", idx);
        end
      end
    if (v.num > 0) begin
      // keep offering a beat past the session end; it must never be taken
      s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = {$urandom, $urandom};
    end
    w = 0;
    while (done_tot == b_done && w < 2000) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    s_axis_tvalid = 1'b0;
    stall_mode = 0;
    for (int i = 0; i < M; i++)
      chk($sformatf("v%0d_beats_p%0d", idx, i), 64'(beats_tot[i] - b_beats[i]), 64'(v.exp_beats[i]));
    chk($sformatf("v%0d_done_count", idx), 64'(done_tot - b_done), 64'd1);
    if (v.num == 0) begin
      chk($sformatf("v%0d_done_cycle", idx), 64'(done_cyc), 64'(c_en + 1));
      chk($sformatf("v%0d_busy_cycles", idx), 64'(busy_tot - b_busy), 64'd0);
      chk($sformatf("v%0d_tready_cycles", idx), 64'(trdy_tot - b_trdy), 64'd0);
    end else begin
      chk($sformatf("v%0d_done_cycle", idx), 64'(done_cyc), 64'(last_m_cyc + 1));
      chk($sformatf("v%0d_busy_seen", idx), 64'(busy_tot - b_busy > 0), 64'd1);
    end
    chk($sformatf("v%0d_extra_accepts", idx), 64'(extra_tot - b_extra), 64'd0);
    left = 0;
    for (int i = 0; i < M; i++) left += sbq[i].size();
    chk($sformatf("v%0d_sb_leftover", idx), 64'(left), 64'd0);
    chk($sformatf("v%0d_busy_after", idx), 64'(fork_busy), 64'd0);
`ifdef AXIS_FORK_STATUS_EN
    for (int i = 0; i < M; i++)
      chk($sformatf("v%0d_pkt_count_p%0d", idx, i), 64'(m_pkt_count[i*PCW +: PCW]), 64'(v.exp_pkts[i]));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int c_en;
    bit ok;
    for (int i = 0; i < M; i++) beats_tot[i] = 0;
    //          mode   sel   num bpp stall  beats per port          packets per port
    vecs[0] = '{2'd0, 3'd0, 6, 2, 0, mk(4, 4, 2, 2), mk(2, 2, 1, 1)};
    vecs[1] = '{2'd1, 3'd0, 2, 3, 2, mk(6, 6, 6, 6), mk(2, 2, 2, 2)};
    vecs[2] = '{2'd2, 3'd5, 1, 4, 0, mk(0, 0, 0, 4), mk(0, 0, 0, 1)};
    vecs[3] = '{2'd0, 3'd0, 0, 1, 0, mk(0, 0, 0, 0), mk(0, 0, 0, 0)};
    vecs[4] = '{2'd2, 3'd1, 2, 1, 1, mk(0, 2, 0, 0), mk(0, 2, 0, 0)};
    vecs[5] = '{2'd3, 3'd0, 5, 1, 1, mk(2, 1, 1, 1), mk(2, 1, 1, 1)};
    vecs[6] = '{2'd0, 3'd0, 9, 1, 0, mk(3, 2, 2, 2), mk(3, 2, 2, 2)};
    vecs[7] = '{2'd1, 3'd0, 3, 2, 1, mk(6, 6, 6, 6), mk(3, 3, 3, 3)};
    post_rst_vec = '{2'd0, 3'd0, 1, 3, 0, mk(3, 0, 0, 0), mk(1, 0, 0, 0)};

    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_m_tdata_any", 64'(|m_axis_tdata), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_busy", 64'(fork_busy), 64'd0);
    chk("rst_done", 64'(fork_done), 64'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_session(vecs[k], k);

    // reset while beat 3 of an 8-beat packet is on offer
    start_session('{2'd0, 3'd0, 1, 8, 0, mk(0, 0, 0, 0), mk(0, 0, 0, 0)}, c_en);
    for (int b = 0; b < 3; b++) begin
      send_beat({$urandom, $urandom}, 1'b0, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL rstseq_beat_timeout actual=stalled expected=accepted");
      end
    end
    s_axis_tvalid = 1'b1; s_axis_tdata = {$urandom, $urandom}; s_axis_tlast = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_m_tdata_any", 64'(|m_axis_tdata), 64'd0);
    chk("midrst_busy", 64'(fork_busy), 64'd0);
    chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    s_axis_tvalid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    chk("postrst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("postrst_busy", 64'(fork_busy), 64'd0);
    @(posedge clk); #1;
    run_session(post_rst_vec, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
